// File: rtl/obf_pkg.sv
// Shared types and constants for the key-locked FSM unlock controller.
package obf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CORE_RST,
    LOAD,
    PROBE,
    CHECK,
    UNLOCKED,
    LOCKOUT
  } state_t;

  localparam int KEY_W_DEF = 5;

  // Key accepted by the group's locked core; benches use it as the correct key.
  localparam logic [KEY_W_DEF-1:0] GROUP_KEY = 5'b10001;

endpackage

// File: rtl/obf_shift_tx.sv
// Load/shift-out register, MSB first, with a bit counter flagging the last bit.
module obf_shift_tx #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         bit_out,
  output logic         last
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= din;
      cnt <= '0;
    end else if (shift) begin
      sr  <= sr << 1;
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_out = sr[W-1];
  // High while the bit currently on bit_out is the final one of the word.
  assign last    = (cnt == CW'(W - 1));

endmodule

// File: rtl/obf_unlock_ctrl.sv
// Unlock controller: resets the locked core, shifts in the key, probes and
// checks the core response, then forwards user traffic or counts the failure.
module obf_unlock_ctrl
  import obf_pkg::*;
#(
  parameter int               KEY_W      = KEY_W_DEF,
  parameter int               RST_CYCLES = 2,
  parameter int               PROBE_W    = 3,
  parameter logic [PROBE_W-1:0] PROBE_SEQ = 3'b111,
  parameter logic             PROBE_EXP  = 1'b1,
  parameter logic             CHECK_PAD  = 1'b0,
  parameter int               MAX_TRIES  = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [KEY_W-1:0]               key_in,
  input  logic                           relock,
  input  logic                           user_x,
  input  logic                           core_out,
  output logic                           fsm_x,
  output logic                           core_rst_n,
  output logic                           busy,
  output logic                           unlocked,
  output logic                           fail_pulse,
  output logic                           locked_out,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt
);

  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  state_t        state, state_nxt;
  logic [RW-1:0] rst_cnt;
  logic          relock_flag;
  logic          accept;
  logic          chk_fail;
  logic [FW-1:0] fail_inc;
  logic          key_bit, key_last;
  logic          pr_bit, pr_last;
  logic          crst_dec;

  assign accept   = (state == IDLE) && start;
  assign chk_fail = (state == CHECK) && (core_out != PROBE_EXP);
  assign fail_inc = fail_cnt + 1'b1;

  obf_shift_tx #(.W(KEY_W)) u_key (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .shift   (state == LOAD),
    .din     (key_in),
    .bit_out (key_bit),
    .last    (key_last)
  );

  obf_shift_tx #(.W(PROBE_W)) u_probe (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .shift   (state == PROBE),
    .din     (PROBE_SEQ),
    .bit_out (pr_bit),
    .last    (pr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rst_cnt     <= '0;
      relock_flag <= 1'b0;
      fail_pulse  <= 1'b0;
      fail_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      rst_cnt    <= (state == CORE_RST) ? rst_cnt + 1'b1 : '0;
      fail_pulse <= chk_fail;
      // The relock flag steers the CORE_RST exit back to IDLE instead of LOAD.
      if (state == UNLOCKED && relock)
        relock_flag <= 1'b1;
      else if (state == CORE_RST && state_nxt != CORE_RST)
        relock_flag <= 1'b0;
      if (chk_fail && fail_cnt != FW'(MAX_TRIES))
        fail_cnt <= fail_inc;
    end
  end

  always_comb begin
    state_nxt  = state;
    fsm_x      = 1'b0;
    crst_dec   = 1'b1;
    busy       = 1'b0;
    unlocked   = 1'b0;
    locked_out = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CORE_RST;
      end
      CORE_RST: begin
        crst_dec = 1'b0;
        busy     = 1'b1;
        if (rst_cnt == RW'(RST_CYCLES - 1))
          state_nxt = relock_flag ? IDLE : LOAD;
      end
      LOAD: begin
        busy  = 1'b1;
        fsm_x = key_bit;
        if (key_last) state_nxt = PROBE;
      end
      PROBE: begin
        busy  = 1'b1;
        fsm_x = pr_bit;
        if (pr_last) state_nxt = CHECK;
      end
      CHECK: begin
        busy  = 1'b1;
        fsm_x = CHECK_PAD;
        if (core_out == PROBE_EXP)
          state_nxt = UNLOCKED;
        else if (fail_inc == FW'(MAX_TRIES))
          state_nxt = LOCKOUT;
        else
          state_nxt = IDLE;
      end
      UNLOCKED: begin
        unlocked = 1'b1;
        fsm_x    = user_x;
        if (relock) state_nxt = CORE_RST;
      end
      LOCKOUT: begin
        crst_dec   = 1'b0;
        locked_out = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Keep the core in reset for as long as the controller itself is in reset.
  assign core_rst_n = rst_n & crst_dec;

endmodule

// File: tb/tb_obf_unlock_ctrl.sv
// Self-checking bench for obf_unlock_ctrl with a behavioural core and controller model.
module tb_obf_unlock_ctrl;
  import obf_pkg::*;

  localparam int         KW   = 5;
  localparam int         RSTC = 2;
  localparam logic [2:0] PSEQ = 3'b111;
  localparam int         MAXT = 3;

  logic       clk = 1'b0;
  logic       rst_n, start, relock, user_x, core_out;
  logic [4:0] key_in;
  logic       fsm_x, core_rst_n, busy, unlocked, fail_pulse, locked_out;
  logic [1:0] fail_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  obf_unlock_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .relock     (relock),
    .user_x     (user_x),
    .core_out   (core_out),
    .fsm_x      (fsm_x),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .unlocked   (unlocked),
    .fail_pulse (fail_pulse),
    .locked_out (locked_out),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Locked core: output goes high once the first KW bits after its reset equal the group key.
  logic hist[$];
  task automatic core_update(input logic s_x, input logic s_crn);
    logic [4:0] f;
    if (!s_crn) begin
      hist.delete();
      core_out = 1'b0;
    end else begin
      hist.push_back(s_x);
      f = '0;
      if (hist.size() >= KW) begin
        for (int i = 0; i < KW; i++) f = {f[3:0], hist[i]};
        core_out = (f == GROUP_KEY);
      end else begin
        core_out = 1'b0;
      end
    end
  endtask

  // Controller model: an attempt is a precomputed schedule of {x, core_rst_n} slots.
  localparam int M_IDLE = 0, M_ATT = 1, M_RELOCK = 2, M_UNL = 3, M_LOCK = 4;
  int         m_mode;
  logic [1:0] m_q[$];
  int         m_fails;
  logic       m_pulse;

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_q.delete();
    m_fails = 0;
    m_pulse = 1'b0;
  endtask

  task automatic model_update(input logic s_rstn, input logic s_start, input logic [4:0] s_key,
                              input logic s_relock, input logic s_cout);
    if (!s_rstn) begin
      model_reset();
      return;
    end
    m_pulse = 1'b0;
    case (m_mode)
      M_IDLE: if (s_start) begin
        m_q.delete();
        repeat (RSTC) m_q.push_back(2'b00);
        for (int i = KW - 1; i >= 0; i--) m_q.push_back({s_key[i], 1'b1});
        for (int i = 2; i >= 0; i--) m_q.push_back({PSEQ[i], 1'b1});
        m_q.push_back(2'b01);
        m_mode = M_ATT;
      end
      M_ATT: begin
        if (m_q.size() == 1) begin
          if (s_cout) m_mode = M_UNL;
          else begin
            if (m_fails < MAXT) m_fails++;
            m_pulse = 1'b1;
            m_mode  = (m_fails == MAXT) ? M_LOCK : M_IDLE;
          end
        end
        void'(m_q.pop_front());
      end
      M_RELOCK: begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_mode = M_IDLE;
      end
      M_UNL: if (s_relock) begin
        m_q.delete();
        repeat (RSTC) m_q.push_back(2'b00);
        m_mode = M_RELOCK;
      end
      default: ;
    endcase
  endtask

  function automatic logic [7:0] model_exp();
    logic [1:0] c;
    c = m_fails[1:0];
    if (!rst_n) return 8'h00;
    case (m_mode)
      M_IDLE:  return {1'b0, 1'b1, 1'b0, 1'b0, m_pulse, 1'b0, c};
      M_ATT, M_RELOCK: return {m_q[0][1], m_q[0][0], 1'b1, 1'b0, m_pulse, 1'b0, c};
      M_UNL:   return {user_x, 1'b1, 1'b0, 1'b1, m_pulse, 1'b0, c};
      default: return {1'b0, 1'b0, 1'b0, 1'b0, m_pulse, 1'b1, c};
    endcase
  endfunction

  function automatic logic [7:0] act_vec();
    return {fsm_x, core_rst_n, busy, unlocked, fail_pulse, locked_out, fail_cnt};
  endfunction

  // One clock: sample pre-edge values, update core and model after the edge, check at negedge.
  task automatic tick();
    logic s_start, s_relock, s_cout, s_x, s_crn, s_rstn;
    logic [4:0] s_key;
    s_start = start; s_relock = relock; s_cout = core_out;
    s_x = fsm_x; s_crn = core_rst_n; s_rstn = rst_n; s_key = key_in;
    @(posedge clk);
    #1;
    core_update(s_x, s_crn);
    model_update(s_rstn, s_start, s_key, s_relock, s_cout);
    @(negedge clk);
    chk("model", {24'h0, act_vec()}, {24'h0, model_exp()});
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("async_reset", {24'h0, act_vec()}, 32'h0);
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_attempt(input logic [4:0] key, input bit disturb, output logic [8:0] seq);
    seq = '0;
    start = 1'b1; key_in = key;
    tick();
    start = 1'b0;
    for (int t = 2; t <= 12; t++) begin
      if (disturb && t >= 3 && t <= 7) begin
        start  = 1'($urandom_range(0, 1));
        key_in = 5'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
      if (t >= 3 && t <= 11) seq = {seq[7:0], fsm_x};
      if (t == 11) chk("unlocked_early", {31'h0, unlocked}, 32'h0);
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [4:0] key;
    bit         disturb;
    logic       exp_unl;
    logic [1:0] exp_cnt;
    logic       exp_lo;
  } vec_t;
  vec_t tbl[6];

  initial begin
    logic [8:0] seq;
    tbl[0] = '{key: 5'b10001, disturb: 0, exp_unl: 1, exp_cnt: 2'd0, exp_lo: 0};
    tbl[1] = '{key: 5'b10011, disturb: 0, exp_unl: 0, exp_cnt: 2'd1, exp_lo: 0};
    tbl[2] = '{key: 5'b10001, disturb: 1, exp_unl: 1, exp_cnt: 2'd1, exp_lo: 0};
    tbl[3] = '{key: 5'b00000, disturb: 0, exp_unl: 0, exp_cnt: 2'd2, exp_lo: 0};
    tbl[4] = '{key: 5'b10001, disturb: 0, exp_unl: 1, exp_cnt: 2'd2, exp_lo: 0};
    tbl[5] = '{key: 5'b11111, disturb: 1, exp_unl: 0, exp_cnt: 2'd3, exp_lo: 1};

    rst_n = 1'b0; start = 1'b0; key_in = '0; relock = 1'b0; user_x = 1'b0; core_out = 1'b0;
    model_reset();
    #3;
    chk("reset_state", {24'h0, act_vec()}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", {24'h0, act_vec()}, 32'h40);

    for (int v = 0; v < 6; v++) begin
      run_attempt(tbl[v].key, tbl[v].disturb, seq);
      chk("fsm_x_seq", {23'h0, seq}, {23'h0, tbl[v].key, PSEQ, 1'b0});
      chk("unlocked", {31'h0, unlocked}, {31'h0, tbl[v].exp_unl});
      chk("fail_pulse", {31'h0, fail_pulse}, {31'h0, ~tbl[v].exp_unl});
      chk("fail_cnt", {30'h0, fail_cnt}, {30'h0, tbl[v].exp_cnt});
      chk("locked_out", {31'h0, locked_out}, {31'h0, tbl[v].exp_lo});
      if (tbl[v].exp_unl) begin
        user_x = 1'b1; #1;
        chk("user_fwd1", {31'h0, fsm_x}, 32'h1);
        user_x = 1'b0; #1;
        chk("user_fwd0", {31'h0, fsm_x}, 32'h0);
        relock = 1'b1; tick(); relock = 1'b0;
        chk("relock_rst1", {31'h0, core_rst_n}, 32'h0);
        tick();
        chk("relock_rst2", {31'h0, core_rst_n}, 32'h0);
        tick();
        chk("relock_idle", {29'h0, core_rst_n, busy, unlocked}, 32'h4);
      end else begin
        tick();
        chk("pulse_one_cycle", {31'h0, fail_pulse}, 32'h0);
      end
    end

    // Lockout ignores further start even with the correct key.
    start = 1'b1; key_in = GROUP_KEY; tick(); start = 1'b0;
    repeat (15) tick();
    chk("lockout_hold", {28'h0, locked_out, unlocked, core_rst_n, 1'b0}, 32'h8);
    chk("lockout_cnt", {30'h0, fail_cnt}, 32'h3);

    // Abort mid-LOAD with a one-cycle reset, then a clean correct attempt.
    reset_pulse();
    run_attempt(5'b10011, 0, seq);
    tick();
    chk("cnt_before_abort", {30'h0, fail_cnt}, 32'h1);
    start = 1'b1; key_in = GROUP_KEY; tick(); start = 1'b0;
    repeat (4) tick();
    chk("in_load", {31'h0, busy}, 32'h1);
    reset_pulse();
    run_attempt(GROUP_KEY, 0, seq);
    chk("unlock_after_abort", {30'h0, unlocked, locked_out}, 32'h2);
    chk("cnt_after_abort", {30'h0, fail_cnt}, 32'h0);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      start  = ($urandom_range(0, 7) == 0);
      key_in = $urandom_range(0, 1) ? GROUP_KEY : 5'($urandom);
      relock = ($urandom_range(0, 15) == 0);
      user_x = 1'($urandom);
      if ($urandom_range(0, 199) == 0) reset_pulse();
      else tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/obf_unlock_ctrl.md
Name: obf_unlock_ctrl

Overview:
Key-loading controller for the obfuscated, key-locked FSM core. On request, it resets the core to its obfuscation start state and shifts a KEY_W-bit key into the core's serial input x, MSB first. It then drives a known probe sequence and checks the core's output to confirm the unlock. On success it passes user traffic through to x; on failure it counts the attempt and locks out after MAX_TRIES failures.

Parameters:
KEY_W, 5, key length in bits (serial unlock sequence length)
RST_CYCLES, 2, cycles core_rst_n is held low before key load (>=1)
PROBE_W, 3, probe sequence length after key load
PROBE_SEQ, 3'b111, probe bits, driven MSB first
PROBE_EXP, 1'b1, value core_out must show during CHECK
CHECK_PAD, 1'b0, value driven on fsm_x during CHECK
MAX_TRIES, 3, failed attempts before permanent lockout (>=1)

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin unlock attempt; sampled in IDLE only
key_in  in  KEY_W  key; captured on the edge that accepts start
relock  in  1  in UNLOCKED: re-reset the core and return to IDLE
user_x  in  1  user serial input, forwarded in UNLOCKED
core_out  in  1  registered output of the locked core
fsm_x  out  1  drives core x
core_rst_n  out  1  core reset (active low); returns core to obfuscation start state
busy  out  1  high in CORE_RST/LOAD/PROBE/CHECK
unlocked  out  1  high in UNLOCKED
fail_pulse  out  1  one-cycle pulse on failed CHECK
locked_out  out  1  high in LOCKOUT
fail_cnt  out  $clog2(MAX_TRIES+1)  failed-attempt count

Behaviour:
- Reset (rst_n low, async): state=IDLE, key shift reg=0, fail_cnt=0. Outputs: fsm_x=0, core_rst_n=0, busy=0, unlocked=0, fail_pulse=0, locked_out=0.
- Outputs are decoded from registered state only. Exception: fsm_x=user_x combinationally in UNLOCKED.
- IDLE: fsm_x=0, core_rst_n=1. start=1 -> capture key_in, go to CORE_RST.
- CORE_RST: core_rst_n=0, fsm_x=0, for exactly RST_CYCLES cycles -> LOAD.
- LOAD: fsm_x=key_sr[KEY_W-1]; shift left each cycle; KEY_W cycles -> PROBE.
- PROBE: fsm_x=PROBE_SEQ bit (MSB first); PROBE_W cycles -> CHECK.
- CHECK: one cycle; fsm_x=CHECK_PAD; compare core_out with PROBE_EXP at the closing edge.
  - Match -> UNLOCKED.
  - Mismatch -> fail_pulse=1 in the next cycle and fail_cnt+1. If the new count equals MAX_TRIES -> LOCKOUT, else -> IDLE.
- UNLOCKED: fsm_x=user_x, core_rst_n=1, unlocked=1. relock=1 -> CORE_RST, then IDLE.
  - Return path after relock: CORE_RST exits to IDLE, not LOAD (tracked by a relock flag).
  - fail_cnt is not cleared by a successful unlock.
- LOCKOUT: fsm_x=0, core_rst_n=0 (core held in reset), locked_out=1. Exits only via rst_n.
- start outside IDLE is ignored. relock outside UNLOCKED is ignored.
- Latency: start accepted at edge E0 -> unlocked high after edge E0+RST_CYCLES+KEY_W+PROBE_W+1. With defaults this is E0+11.
- fail_cnt saturates at MAX_TRIES; it never wraps.
- rst_n assertion mid-attempt aborts immediately. After reset release the next attempt starts cleanly from IDLE.

Decomposition:
- Shared package (obf_pkg): state enum {IDLE, CORE_RST, LOAD, PROBE, CHECK, UNLOCKED, LOCKOUT}, default KEY_W, and the group key constant GROUP_KEY=5'b10001 for benches.
- One sub-module is natural: obf_shift_tx, a generic load/shift-out register with bit counter and done flag.
  - One instance for the key, one for the probe sequence.
- FSM and fail counter stay in the top.

Test Plan:
- Correct key 5'b10001, defaults -> fsm_x reads 1,0,0,0,1 then 1,1,1 then 0. core_out=1 during CHECK. unlocked=1 at E0+11, fail_cnt=0, fsm_x follows user_x.
- Wrong key 5'b10011 (core blackholes, core_out=0) -> fail_pulse for exactly one cycle, fail_cnt=1, return to IDLE, unlocked stays 0.
- Three consecutive wrong keys -> fail_cnt=3, locked_out=1, core_rst_n=0. A further start with 5'b10001 is ignored.
- start pulsed repeatedly during LOAD -> ignored. key_in changed mid-LOAD -> the sequence on fsm_x is unaffected.
- rst_n low for one cycle mid-LOAD -> all outputs at reset values immediately, fail_cnt=0. A subsequent correct-key attempt unlocks in 11 cycles.
- UNLOCKED then relock=1 -> core_rst_n low 2 cycles, then IDLE with unlocked=0. A re-attempt with 5'b10001 unlocks again.
